// File: rtl/lfsr_pkg.sv
// Shared LFSR stream-cipher definitions (constants, FSM state, keystream step, CRC-8 update).
// Used by both the encryptor and the decryptor so both ends generate the same keystream.
package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam int DATA_W = 8;
  localparam logic [LFSR_W-1:0] TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [7:0]        CRC_POLY     = 8'h07;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Galois right-shift LFSR advanced n single-bit steps
  function automatic logic [LFSR_W-1:0] lfsr_step_n(input logic [LFSR_W-1:0] s, input int n);
    logic [LFSR_W-1:0] v;
    v = s;
    for (int i = 0; i < n; i++) begin
      v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    end
    return v;
  endfunction

  // CRC-8, MSB first, one data byte per call
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/lfsr_stream_decrypt_if.sv
// Ciphertext-in / plaintext-out valid/ready stream bundle for the LFSR decryptor.
interface lfsr_stream_decrypt_if;
  import lfsr_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lfsr_keystream.sv
// Keystream generator: LFSR state with seed load (all-zero seed replaced by the default)
// and a DATA_W-step advance per accepted byte.
module lfsr_keystream
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [DATA_W-1:0] ks
);

  logic [LFSR_W-1:0] lfsr_p0;

  // stage 0: keystream state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_p0 <= DEFAULT_SEED;
    end else if (ena) begin
      if (load) begin
        lfsr_p0 <= (seed == '0) ? DEFAULT_SEED : seed;
      end else if (advance) begin
        lfsr_p0 <= lfsr_step_n(lfsr_p0, DATA_W);
      end
    end
  end

  assign ks = lfsr_p0[DATA_W-1:0];

endmodule

// File: rtl/lfsr_stream_decrypt.sv
// LFSR stream decryptor: ciphertext XOR regenerated keystream, one registered output stage.
// Define LFSR_DECRYPT_CRC_EN to build the running CRC-8 of plaintext; otherwise crc_out is 0.
module lfsr_stream_decrypt
  import lfsr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  seed_load,
  input  logic [LFSR_W-1:0]     seed_in,
  lfsr_stream_decrypt_if.slave  strm,
  output logic [15:0]           byte_count,
  output logic [7:0]            crc_out
);

  state_t            state, state_nxt;
  logic              ready, accept, drain;
  logic [DATA_W-1:0] ks;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [15:0]       count_p1;

  lfsr_keystream u_keystream (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .load    (seed_load),
    .seed    (seed_in),
    .advance (accept),
    .ks      (ks)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!seed_load && accept) state_nxt = RUN;
      RUN:  if (seed_load)            state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready  = ena && !seed_load && (!vld_p1 || strm.out_ready);
    accept = strm.in_valid && ready;
    drain  = ena && vld_p1 && strm.out_ready;
  end

  // stage 1: plaintext output register; seed_load drops any pending byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (ena) begin
      if (seed_load) begin
        vld_p1 <= 1'b0;
      end else if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= strm.in_data ^ ks;
      end else if (drain) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p1 <= '0;
    end else if (ena) begin
      if (seed_load)  count_p1 <= '0;
      else if (drain) count_p1 <= count_p1 + 16'd1;
    end
  end

`ifdef LFSR_DECRYPT_CRC_EN
  logic [7:0] crc_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_p1 <= '0;
    end else if (ena) begin
      if (seed_load)  crc_p1 <= '0;
      else if (drain) crc_p1 <= crc8_update(crc_p1, data_p1);
    end
  end

  assign crc_out = crc_p1;
`else
  assign crc_out = 8'h00;
`endif

  assign strm.in_ready  = ready;
  assign strm.out_valid = vld_p1;
  assign strm.out_data  = data_p1;
  assign byte_count     = count_p1;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Directed bench for lfsr_stream_decrypt: reference encryptor model, backpressure, seed, wrap, CRC.
module tb_lfsr_stream_decrypt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [15:0] byte_count;
  logic [7:0]  crc_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m;  // reference encryptor keystream state

  lfsr_stream_decrypt_if bus ();

  lfsr_stream_decrypt dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .strm       (bus),
    .byte_count (byte_count),
    .crc_out    (crc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] m_adv(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < 8; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // encrypt one plaintext byte with the reference model
  function automatic logic [7:0] enc(input logic [7:0] p);
    logic [7:0] c;
    c = p ^ m[7:0];
    m = m_adv(m);
    return c;
  endfunction

  task automatic load_seed(input logic [15:0] s);
    bus.in_valid = 1'b0;
    seed_in      = s;
    seed_load    = 1'b1;
    tick();
    seed_load    = 1'b0;
    m            = (s == 16'h0000) ? 16'hACE1 : s;
  endtask

  initial begin
    logic [7:0] p [0:255];
    logic [7:0] q [0:3];
    string      msg;

    rst_n = 1'b0; ena = 1'b1; seed_load = 1'b0; seed_in = 16'h0000;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b1;
    m = 16'hACE1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_count",     32'(byte_count),    32'h0);
    chk("rst_crc",       32'(crc_out),       32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // 1: first byte after reset, keystream byte is E1
    bus.in_data = 8'h00; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_data",  32'(bus.out_data),  32'hE1);
    tick();
    chk("t1_count", 32'(byte_count), 32'd1);
    chk("t1_drain", 32'(bus.out_valid), 32'h0);

    // 2: loopback of 256 random bytes, seed 1234
    load_seed(16'h1234);
    chk("t2_count_clr", 32'(byte_count), 32'h0);
    for (int i = 0; i < 256; i++) begin
      p[i] = 8'($urandom);
      bus.in_data  = enc(p[i]);
      bus.in_valid = 1'b1;
      tick();
      chk($sformatf("t2_pt%0d", i), {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, p[i]});
    end
    bus.in_valid = 1'b0;
    tick();
    chk("t2_count", 32'(byte_count), 32'd256);
`ifndef LFSR_DECRYPT_CRC_EN
    chk("t2_crc_off", 32'(crc_out), 32'h0);
`endif

    // 3: backpressure holds output and keystream
    load_seed(16'h5555);
    for (int i = 0; i < 4; i++) q[i] = 8'($urandom);
    bus.out_ready = 1'b0;
    bus.in_data = enc(q[0]); bus.in_valid = 1'b1;
    tick();
    bus.in_data = enc(q[1]);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_rdy%0d", i),  32'(bus.in_ready),  32'h0);
      chk($sformatf("t3_hold%0d", i), {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, q[0]});
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t3_resume1", 32'(bus.out_data), 32'(q[1]));
    bus.in_data = enc(q[2]);
    tick();
    chk("t3_resume2", 32'(bus.out_data), 32'(q[2]));
    bus.in_valid = 1'b0;
    tick();
    chk("t3_count", 32'(byte_count), 32'd3);

    // 4: seed_load drops pending byte; zero seed falls back to default
    bus.out_ready = 1'b0;
    bus.in_data = enc(q[3]); bus.in_valid = 1'b1;
    tick();
    chk("t4_pending", 32'(bus.out_valid), 32'h1);
    seed_in = 16'h0000; seed_load = 1'b1; bus.in_data = 8'h77;
    #1;
    chk("t4_rdy_low", 32'(bus.in_ready), 32'h0);
    tick();
    seed_load = 1'b0; bus.in_valid = 1'b0;
    chk("t4_dropped", 32'(bus.out_valid), 32'h0);
    chk("t4_count",   32'(byte_count),    32'h0);
    bus.out_ready = 1'b1;
    bus.in_data = 8'h00; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t4_default", 32'(bus.out_data), 32'hE1);
    tick();

    // ena low freezes everything mid-stream
    load_seed(16'hBEEF);
    q[0] = 8'h3C; q[1] = 8'hA5;
    bus.in_data = enc(q[0]); bus.in_valid = 1'b1;
    tick();
    bus.in_data = enc(q[1]);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ena_rdy%0d", i), 32'(bus.in_ready), 32'h0);
      tick();
      chk($sformatf("ena_hold%0d", i), {7'd0, bus.out_valid, byte_count, bus.out_data},
          {7'd0, 1'b1, 16'd0, q[0]});
    end
    ena = 1'b1;
    tick();
    chk("ena_resume", {15'd0, byte_count, bus.out_data}, {15'd0, 16'd1, q[1]});
    bus.in_valid = 1'b0;
    tick();

    // reset mid-stream is immediate
    bus.in_data = 8'h55; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_state", {15'd0, bus.out_valid, byte_count, bus.out_data}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_data = 8'h00; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("arst_seed", 32'(bus.out_data), 32'hE1);
    tick();

    // 6: CRC of "123456789"
    load_seed(16'h0001);
    msg = "123456789";
    for (int i = 0; i < 9; i++) begin
      bus.in_data = enc(msg[i]); bus.in_valid = 1'b1;
      tick();
      chk($sformatf("crc_pt%0d", i), 32'(bus.out_data), 32'(msg[i]));
    end
    bus.in_valid = 1'b0;
    tick();
`ifdef LFSR_DECRYPT_CRC_EN
    chk("crc_check", 32'(crc_out), 32'hF4);
`else
    chk("crc_off", 32'(crc_out), 32'h00);
`endif

    // 5: byte_count wraps FFFF -> 0000
    load_seed(16'h2468);
    bus.in_valid = 1'b1;
    repeat (65535) tick();
    bus.in_valid = 1'b0;
    tick();
    chk("wrap_ffff", 32'(byte_count), 32'hFFFF);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("wrap_pending", 32'(byte_count), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(byte_count), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
